ifm_pingpong_write_ctrl: RTL
============================

# ifm_pingpong_write_ctrl

Write-side controller for the two-bank ping-pong IFM memory array (`ifm_sel`, `ifm_enable_write_previous`, `ifm_address_write_previous`, `data_in_from_previous1`).

- Accepts the previous layer's output as a valid/ready pixel stream and writes one IFM frame of `IFM_SIZE*IFM_SIZE` words into the write bank, row-major.
- Swaps banks only when the next layer has released the read bank, then pulses `next_start` so the next layer begins reading the newly filled bank.
- Sits directly upstream of the memory array, between the previous layer's output and the array's write port.

## Interface
Parameters:
- `DATA_WIDTH`, 32, pixel word width.
- `IFM_SIZE`, 28, frame edge length; one frame is `IFM_SIZE*IFM_SIZE` words.
- `ADDRESS_SIZE_IFM`, `$clog2(IFM_SIZE*IFM_SIZE)`, write address width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block accepts a word this cycle.
- `in_data`  in  `DATA_WIDTH`  upstream word.
- `ifm_sel`  out  1  bank select: 0 = write Mem1 / next reads Mem2; 1 = the reverse.
- `ifm_enable_write_previous`  out  1  registered write strobe to the array.
- `ifm_address_write_previous`  out  `ADDRESS_SIZE_IFM`  registered write address.
- `data_in_from_previous1`  out  `DATA_WIDTH`  registered write data.
- `next_start`  out  1  one-cycle pulse: read bank is now valid.
- `next_done`  in  1  one-cycle pulse from the next layer: finished with its read bank.
- `frame_count`  out  16  completed-and-swapped frames, wraps at 2^16.
- `err_spurious_done`  out  1  sticky; set by `next_done` while not busy.

## Operation
- Reset (`rst_n`=0 at an edge) sets:
  - state FILL, `wr_addr`=0, `ifm_sel`=0, `next_busy`=0, `frame_count`=0, `err_spurious_done`=0;
  - `ifm_enable_write_previous`=0, `ifm_address_write_previous`=0, `data_in_from_previous1`=0, `next_start`=0.
- `in_ready` = (state==FILL). It is decoded from registered state only and has no combinational path from `in_valid`.
- Handshake: a word transfers on an edge where `in_valid && in_ready`.
- FILL state, on each handshake:
  - Register `ifm_enable_write_previous`=1, address=`wr_addr`, data=`in_data`.
  - Increment `wr_addr`.
  - If `wr_addr`==`IFM_SIZE*IFM_SIZE-1`: set `wr_addr` to 0 and go to SWAP_WAIT.
  - With no handshake, the registered write enable returns to 0 on the next edge.
- SWAP_WAIT state:
  - `in_ready`=0.
  - Swap condition: `!next_busy || next_done`.
  - On an edge with the swap condition true: toggle `ifm_sel`, register `next_start`=1 for exactly one cycle, set `next_busy`=1, increment `frame_count`, go to FILL.
  - If the condition is false, stay in SWAP_WAIT.
- `next_busy` tracking:
  - Cleared by `next_done`.
  - Set by a swap.
  - Swap and `next_done` on the same edge: set wins (the done releases the old bank, the swap claims the new one).
- `next_done` while `next_busy`=0 and not in SWAP_WAIT: ignored, and sets `err_spurious_done`. Only reset clears it.
- `in_data` is never written while in SWAP_WAIT; no word is dropped or duplicated.
- Reset mid-frame discards the partial frame. The next frame restarts at address 0 in Mem1 (`ifm_sel`=0).

## Timing
- Write latency: handshake at edge E → the array sees enable/address/data during cycle E..E+1 → the array writes at E+1.
- Swap latency:
  - Last handshake at E0 → state SWAP_WAIT from E0.
  - Earliest `ifm_sel` toggle is at E1, so the final word's write at E1 still uses the old `ifm_sel`.
  - `next_start` is high during E1..E2.
  - `in_ready` is high again from E1.
- Throughput: one word per cycle within a frame; minimum one idle cycle per frame boundary.
- `ifm_sel` changes only on swap edges and is stable for a whole frame.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1 → all outputs 0, `in_ready`=1 after release, no write strobe while in reset.
- Single frame, `IFM_SIZE`=4, `in_valid` continuously high, data = 100+i:
  - writes at addresses 0..15 with data 100..115, `ifm_sel`=0 throughout;
  - `ifm_sel`=1 and one `next_start` pulse the cycle after the 16th handshake; `frame_count`=1.
- Backpressure: second frame while `next_done` is withheld → `in_ready`=0 after the 16th word; hold for 20 cycles, then pulse `next_done` → swap on that edge, `ifm_sel`=0, `frame_count`=2.
- Same-edge done and swap: `next_done` in the SWAP_WAIT cycle → swap occurs, `next_busy` remains 1, no error.
- Gapped input: `in_valid` toggling 1/0 → addresses contiguous, write strobe high only on handshake+1 cycles.
- Faults:
  - `next_done` pulse right after reset → `err_spurious_done`=1, state unaffected.
  - `rst_n` pulsed after 7 words → restart at address 0, `ifm_sel`=0, `frame_count`=0.

Source files
------------

// File: rtl/ifm_pingpong_write_ctrl.sv
// Write-side controller for the two-bank ping-pong IFM array: streams one frame
// into the write bank, then swaps banks once the next layer releases its read bank.
module ifm_pingpong_write_ctrl #(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 28,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        ifm_sel,
  output logic                        ifm_enable_write_previous,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_write_previous,
  output logic [DATA_WIDTH-1:0]       data_in_from_previous1,
  output logic                        next_start,
  input  logic                        next_done,
  output logic [15:0]                 frame_count,
  output logic                        err_spurious_done
);

  typedef enum logic [0:0] {
    FILL      = 1'b0,
    SWAP_WAIT = 1'b1
  } state_t;

  localparam logic [ADDRESS_SIZE_IFM-1:0] LAST_ADDR = ADDRESS_SIZE_IFM'(IFM_SIZE*IFM_SIZE-1);

  state_t                        state_r, state_s;
  logic [ADDRESS_SIZE_IFM-1:0]   wr_addr_r, wr_addr_s;
  logic                          next_busy_r, next_busy_s;
  logic                          swap_s;
  logic                          we_s;
  logic [ADDRESS_SIZE_IFM-1:0]   addr_s;
  logic [DATA_WIDTH-1:0]         data_s;
  logic                          sel_s;
  logic [15:0]                   frame_count_s;
  logic                          err_s;

  // Ready depends on registered state only, never on in_valid.
  assign in_ready = (state_r == FILL);

  // Next-state, write-port and swap decode.
  always_comb begin
    state_s       = state_r;
    wr_addr_s     = wr_addr_r;
    swap_s        = 1'b0;
    we_s          = 1'b0;
    addr_s        = ifm_address_write_previous;
    data_s        = data_in_from_previous1;
    sel_s         = ifm_sel;
    frame_count_s = frame_count;
    case (state_r)
      FILL: begin
        if (in_valid) begin
          we_s   = 1'b1;
          addr_s = wr_addr_r;
          data_s = in_data;
          if (wr_addr_r == LAST_ADDR) begin
            wr_addr_s = '0;
            state_s   = SWAP_WAIT;
          end else begin
            wr_addr_s = wr_addr_r + ADDRESS_SIZE_IFM'(1'b1);
          end
        end else begin
          we_s = 1'b0;
        end
      end
      SWAP_WAIT: begin
        // A done on this edge frees the old read bank, so the swap may proceed.
        if (!next_busy_r || next_done) begin
          swap_s        = 1'b1;
          sel_s         = ~ifm_sel;
          frame_count_s = frame_count + 16'd1;
          state_s       = FILL;
        end else begin
          state_s = SWAP_WAIT;
        end
      end
      default: begin
        state_s   = FILL;
        wr_addr_s = '0;
      end
    endcase
  end

  // Reader-occupancy tracking; a swap on the same edge as a done keeps it set.
  always_comb begin
    if (swap_s) begin
      next_busy_s = 1'b1;
    end else if (next_done) begin
      next_busy_s = 1'b0;
    end else begin
      next_busy_s = next_busy_r;
    end
  end

  // Sticky flag for a done pulse that no reader could have produced.
  always_comb begin
    if (next_done && !next_busy_r && (state_r != SWAP_WAIT)) begin
      err_s = 1'b1;
    end else begin
      err_s = err_spurious_done;
    end
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r                    <= FILL;
      wr_addr_r                  <= '0;
      next_busy_r                <= 1'b0;
      ifm_sel                    <= 1'b0;
      ifm_enable_write_previous  <= 1'b0;
      ifm_address_write_previous <= '0;
      data_in_from_previous1     <= '0;
      next_start                 <= 1'b0;
      frame_count                <= 16'd0;
      err_spurious_done          <= 1'b0;
    end else begin
      state_r                    <= state_s;
      wr_addr_r                  <= wr_addr_s;
      next_busy_r                <= next_busy_s;
      ifm_sel                    <= sel_s;
      ifm_enable_write_previous  <= we_s;
      ifm_address_write_previous <= addr_s;
      data_in_from_previous1     <= data_s;
      next_start                 <= swap_s;
      frame_count                <= frame_count_s;
      err_spurious_done          <= err_s;
    end
  end

endmodule
